// File: rtl/mem_lane_pkg.sv
// Shared types and constants for the byte-lane memory controller.
package mem_lane_pkg;

    localparam int LANES  = 4;
    localparam int ROW_W  = 10;
    localparam int ADDR_W = ROW_W + 2;

    // Access sizes as carried on d_size; 2'd3 is reserved and behaves as a word.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Number of bytes moved by an access of the given size.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    // Sign- or zero-extend the low byte/half of an assembled load.
    function automatic logic [31:0] load_extend(input logic [31:0] w,
                                                input logic [1:0]  sz,
                                                input logic        uns);
        case (sz)
            SZ_B:    load_extend = uns ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            SZ_H:    load_extend = uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: load_extend = w;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_ctrl_lane_mapper.sv
// Maps an access (byte offset, byte count, beat index) onto the four lanes:
// which lanes are touched in this beat, the write data rotated into lane
// positions, and for every lane the access byte index it carries.
module lane_mapper
    import mem_lane_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  n_i,
    input  logic        beat_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wbytes_o,
    output logic [7:0]  pos_o
);

    logic [1:0] idx;
    logic       touched;
    logic       in_first_row;

    // Lane k holds access byte (k - off) mod 4; it lives in the first row when k >= off.
    always_comb begin
        sel_o        = '0;
        wbytes_o     = '0;
        pos_o        = '0;
        idx          = '0;
        touched      = 1'b0;
        in_first_row = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            idx          = 2'(k) - off_i;
            touched      = ({1'b0, idx} < n_i);
            in_first_row = (2'(k) >= off_i);
            sel_o[k]     = touched && (beat_i ? !in_first_row : in_first_row);
            wbytes_o[8*k +: 8] = wdata_i[8*idx +: 8];
            pos_o[2*k +: 2]    = idx;
        end
    end

endmodule

// File: rtl/mem_lane_ctrl.sv
// Sequences the four byte-lane banks for a fetch port and a load/store port.
// Handshake: a port holds req until its ready pulses (ready is combinational,
// only in IDLE); exactly one rvalid pulse per accepted access follows.
module mem_lane_ctrl
    import mem_lane_pkg::*;
#(
    parameter int ROW_W  = mem_lane_pkg::ROW_W,
    parameter int ADDR_W = mem_lane_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic [ROW_W-1:0]  lane_addr,
    output logic [3:0]        lane_sel,
    output logic              lane_we,
    output logic [31:0]       lane_d,
    input  logic [31:0]       lane_q
);

    state_e            state_q;
    logic              ptr_q;      // 1: D granted last, 0: I granted last
    logic              is_d_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic [ROW_W-1:0]  row_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic [31:0]       asm_d;

    logic [ROW_W-1:0]  lane_addr_q;
    logic [3:0]        lane_sel_q;
    logic              lane_we_q;
    logic [31:0]       lane_d_q;
    logic              i_rvalid_q, d_rvalid_q;
    logic [31:0]       i_rdata_q, d_rdata_q;

    logic              gnt_d, gnt_i;
    logic [1:0]        m_off;
    logic [2:0]        m_n;
    logic              m_beat;
    logic [31:0]       m_wdata;
    logic [3:0]        map_sel;
    logic [31:0]       map_wbytes;
    logic [7:0]        map_pos;
    logic              crossing;
    logic              last_beat;
    logic [31:0]       resp_data;
    logic [ROW_W-1:0]  req_row;
    logic              unused_fetch_off;

    // Fetches are always whole aligned words; the low address bits carry no meaning.
    assign unused_fetch_off = ^i_addr[1:0];

    // Round-robin grant, only while idle; D wins a tie when I was granted last.
    always_comb begin
        gnt_d = 1'b0;
        gnt_i = 1'b0;
        if (state_q == IDLE) begin
            gnt_d = d_req && (!i_req || !ptr_q);
            gnt_i = i_req && !gnt_d;
        end
    end

    assign i_ready = gnt_i;
    assign d_ready = gnt_d;
    assign req_row = gnt_d ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2];

    // Mapper sees the incoming request while idle (first beat) and the latched one afterwards.
    always_comb begin
        m_off   = off_q;
        m_n     = size_bytes(size_q);
        m_beat  = 1'b1;
        m_wdata = wdata_q;
        if (state_q == IDLE) begin
            m_beat = 1'b0;
            if (gnt_d) begin
                m_off   = d_addr[1:0];
                m_n     = size_bytes(d_size);
                m_wdata = d_wdata;
            end else begin
                m_off   = 2'd0;
                m_n     = 3'd4;
                m_wdata = '0;
            end
        end
    end

    lane_mapper u_map (
        .off_i    (m_off),
        .n_i      (m_n),
        .beat_i   (m_beat),
        .wdata_i  (m_wdata),
        .sel_o    (map_sel),
        .wbytes_o (map_wbytes),
        .pos_o    (map_pos)
    );

    // Merge the bytes of the lanes active in this beat into their access positions.
    always_comb begin
        asm_d = asm_q;
        for (int k = 0; k < LANES; k++) begin
            if (lane_sel_q[k]) asm_d[8*map_pos[2*k +: 2] +: 8] = lane_q[8*k +: 8];
        end
    end

    assign crossing  = ({1'b0, off_q} + size_bytes(size_q)) > 3'd4;
    assign last_beat = (state_q == BEAT2) || ((state_q == BEAT1) && !crossing);
    assign resp_data = is_d_q ? (we_q ? 32'd0 : load_extend(asm_d, size_q, uns_q)) : asm_d;

    // Controller FSM: accept, one or two lane beats, then a one-cycle response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            is_d_q      <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            off_q       <= '0;
            row_q       <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            lane_addr_q <= '0;
            lane_sel_q  <= '0;
            lane_we_q   <= 1'b0;
            lane_d_q    <= '0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_d || gnt_i) begin
                        ptr_q       <= gnt_d;
                        is_d_q      <= gnt_d;
                        we_q        <= gnt_d && d_we;
                        size_q      <= gnt_d ? d_size : SZ_W;
                        uns_q       <= d_unsigned;
                        off_q       <= m_off;
                        row_q       <= req_row;
                        wdata_q     <= m_wdata;
                        asm_q       <= '0;
                        lane_addr_q <= req_row;
                        lane_sel_q  <= map_sel;
                        lane_we_q   <= gnt_d && d_we;
                        if (gnt_d && d_we) lane_d_q <= map_wbytes;
                        state_q     <= BEAT1;
                    end
                end
                BEAT1: begin
                    asm_q <= asm_d;
                    if (crossing) begin
                        lane_addr_q <= row_q + 1'b1;
                        lane_sel_q  <= map_sel;
                        state_q     <= BEAT2;
                    end else begin
                        lane_sel_q  <= '0;
                        lane_we_q   <= 1'b0;
                        state_q     <= RESP;
                    end
                end
                BEAT2: begin
                    asm_q      <= asm_d;
                    lane_sel_q <= '0;
                    lane_we_q  <= 1'b0;
                    state_q    <= RESP;
                end
                RESP: begin
                    i_rvalid_q <= 1'b0;
                    d_rvalid_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (last_beat) begin
                if (is_d_q) begin
                    d_rvalid_q <= 1'b1;
                    d_rdata_q  <= resp_data;
                end else begin
                    i_rvalid_q <= 1'b1;
                    i_rdata_q  <= resp_data;
                end
            end
        end
    end

    assign i_rvalid  = i_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign lane_addr = lane_addr_q;
    assign lane_sel  = lane_sel_q;
    assign lane_we   = lane_we_q;
    assign lane_d    = lane_d_q;

endmodule

// File: tb/tb_mem_lane_ctrl.sv
// Directed bench for mem_lane_ctrl with a byte-lane memory model.
module tb_mem_lane_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [11:0] i_addr = '0;
    logic        i_ready, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = '0;
    logic        d_unsigned = 1'b0;
    logic [11:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready, d_rvalid;
    logic [31:0] d_rdata;
    logic [9:0]  lane_addr;
    logic [3:0]  lane_sel;
    logic        lane_we;
    logic [31:0] lane_d;
    logic [31:0] lane_q;

    logic        mem_clr = 1'b1;
    logic [7:0]  mem [4][1024];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [3:0]  exp_s1;
        logic [9:0]  exp_a1;
        logic [3:0]  exp_s2;
        logic [9:0]  exp_a2;
    } vec_t;

    vec_t vecs[12];

    // Clock
    always #5 clk = ~clk;

    mem_lane_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ready    (i_ready),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_size     (d_size),
        .d_unsigned (d_unsigned),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .lane_addr  (lane_addr),
        .lane_sel   (lane_sel),
        .lane_we    (lane_we),
        .lane_d     (lane_d),
        .lane_q     (lane_q)
    );

    // Lane banks: combinational read, write at the clock edge under lane_sel.
    always_comb begin
        lane_q = '0;
        for (int k = 0; k < 4; k++) lane_q[8*k +: 8] = mem[k][lane_addr];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 4; k++)
                for (int r = 0; r < 1024; r++) mem[k][r] <= 8'h00;
        end else if (lane_we) begin
            for (int k = 0; k < 4; k++)
                if (lane_sel[k]) mem[k][lane_addr] <= lane_d[8*k +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one access, wait for ready and rvalid, and record the lane beats.
    task automatic access(input logic is_d, input logic we, input logic [1:0] size,
                          input logic uns, input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat,
                          output logic [3:0] s1, output logic [9:0] a1, output logic we1,
                          output logic [3:0] s2, output logic [9:0] a2);
        logic got;
        rdata = '0; lat = 0; s1 = '0; a1 = '0; we1 = 1'b0; s2 = '0; a2 = '0;
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns;
            d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (is_d ? d_ready : i_ready) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            check("ready_timeout", {31'd0, got}, 32'd1);
            d_req = 1'b0; i_req = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        d_req = 1'b0; i_req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin s1 = lane_sel; a1 = lane_addr; we1 = lane_we; end
            if (c == 2) begin s2 = lane_sel; a2 = lane_addr; end
            if (is_d ? d_rvalid : i_rvalid) begin
                lat = c;
                rdata = is_d ? d_rdata : i_rdata;
                break;
            end
        end
    endtask

    logic [31:0] rd;
    int          lat;
    logic [3:0]  s1, s2;
    logic [9:0]  a1, a2;
    logic        we1;
    logic        rec [4];
    logic        exp_g [4];
    int          g;

    initial begin
        // Reset block
        rst_n = 1'b0;
        mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_handshake", {28'd0, i_ready, d_ready, i_rvalid, d_rvalid}, 32'd0);
        check("rst_lane_ctl", {27'd0, lane_sel, lane_we}, 32'd0);
        check("rst_lane_addr", {22'd0, lane_addr}, 32'd0);
        check("rst_lane_d", lane_d, 32'd0);
        check("rst_rdata", i_rdata | d_rdata, 32'd0);
        mem_clr = 1'b0;
        rst_n = 1'b1;

        // Vector table: is_d we size uns addr wdata exp lat s1 a1 s2 a2
        vecs[0]  = '{1'b1, 1'b1, 2'd2, 1'b0, 12'h005, 32'h11223344, 32'h00000000, 3, 4'b1110, 10'd1, 4'b0001, 10'd2};
        vecs[1]  = '{1'b1, 1'b0, 2'd2, 1'b0, 12'h005, 32'h00000000, 32'h11223344, 3, 4'b1110, 10'd1, 4'b0001, 10'd2};
        vecs[2]  = '{1'b1, 1'b1, 2'd0, 1'b0, 12'h003, 32'hDEADBE80, 32'h00000000, 2, 4'b1000, 10'd0, 4'b0000, 10'd0};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 12'h003, 32'h00000000, 32'hFFFFFF80, 2, 4'b1000, 10'd0, 4'b0000, 10'd0};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 1'b1, 12'h003, 32'h00000000, 32'h00000080, 2, 4'b1000, 10'd0, 4'b0000, 10'd0};
        vecs[5]  = '{1'b1, 1'b1, 2'd1, 1'b0, 12'h00A, 32'h0000BEEF, 32'h00000000, 2, 4'b1100, 10'd2, 4'b0000, 10'd2};
        vecs[6]  = '{1'b1, 1'b0, 2'd1, 1'b0, 12'h00A, 32'h00000000, 32'hFFFFBEEF, 2, 4'b1100, 10'd2, 4'b0000, 10'd2};
        vecs[7]  = '{1'b1, 1'b0, 2'd1, 1'b1, 12'h00A, 32'h00000000, 32'h0000BEEF, 2, 4'b1100, 10'd2, 4'b0000, 10'd2};
        vecs[8]  = '{1'b1, 1'b0, 2'd0, 1'b0, 12'h006, 32'h00000000, 32'h00000033, 2, 4'b0100, 10'd1, 4'b0000, 10'd1};
        vecs[9]  = '{1'b1, 1'b0, 2'd1, 1'b1, 12'h007, 32'h00000000, 32'h00001122, 3, 4'b1000, 10'd1, 4'b0001, 10'd2};
        vecs[10] = '{1'b1, 1'b0, 2'd3, 1'b0, 12'h004, 32'h00000000, 32'h22334400, 2, 4'b1111, 10'd1, 4'b0000, 10'd1};
        vecs[11] = '{1'b0, 1'b0, 2'd2, 1'b0, 12'h009, 32'h00000000, 32'hBEEF0011, 2, 4'b1111, 10'd2, 4'b0000, 10'd2};

        for (int v = 0; v < 12; v++) begin
            access(vecs[v].is_d, vecs[v].we, vecs[v].size, vecs[v].uns, vecs[v].addr,
                   vecs[v].wdata, rd, lat, s1, a1, we1, s2, a2);
            check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
            check($sformatf("v%0d_lat", v), lat, vecs[v].exp_lat);
            check($sformatf("v%0d_beat1", v), {17'd0, we1, a1, s1}, {17'd0, vecs[v].we, vecs[v].exp_a1, vecs[v].exp_s1});
            check($sformatf("v%0d_beat2", v), {18'd0, a2, s2}, {18'd0, vecs[v].exp_a2, vecs[v].exp_s2});
        end

        // Row wrap: half load at the top byte splits into row 1023 then row 0.
        access(1'b1, 1'b1, 2'd0, 1'b0, 12'hFFF, 32'h000000A5, rd, lat, s1, a1, we1, s2, a2);
        access(1'b1, 1'b1, 2'd0, 1'b0, 12'h000, 32'h0000009A, rd, lat, s1, a1, we1, s2, a2);
        access(1'b1, 1'b0, 2'd1, 1'b0, 12'hFFF, 32'h00000000, rd, lat, s1, a1, we1, s2, a2);
        check("wrap_rdata", rd, 32'hFFFF9AA5);
        check("wrap_lat", lat, 3);
        check("wrap_beat1", {18'd0, a1, s1}, {18'd0, 10'd1023, 4'b1000});
        check("wrap_beat2", {18'd0, a2, s2}, {18'd0, 10'd0, 4'b0001});

        // Reset during the second beat of a split store.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_unsigned = 1'b0;
        d_addr = 12'h006; d_wdata = 32'hCAFEF00D;
        #1;
        check("rb_ready", {31'd0, d_ready}, 32'd1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
        @(negedge clk);
        check("rb_beat1", {27'd0, lane_we, lane_sel}, {27'd0, 1'b1, 4'b1100});
        @(negedge clk);
        check("rb_beat2", {17'd0, lane_we, lane_addr, lane_sel}, {17'd0, 1'b1, 10'd2, 4'b0011});
        rst_n = 1'b0;
        #1;
        check("rb_outs", {19'd0, i_ready, d_ready, i_rvalid, d_rvalid, lane_sel, lane_we, 4'd0},
              32'd0);
        check("rb_addr_d", {lane_addr, 22'd0} | lane_d | i_rdata | d_rdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rb_row1", {16'd0, mem[3][1], mem[2][1]}, {16'd0, 8'hF0, 8'h0D});
        check("rb_row2", {16'd0, mem[1][2], mem[0][2]}, {16'd0, 8'h00, 8'h11});
        rst_n = 1'b1;
        access(1'b1, 1'b0, 2'd2, 1'b0, 12'h004, 32'h00000000, rd, lat, s1, a1, we1, s2, a2);
        check("rb_next_rdata", rd, 32'hF00D4400);
        check("rb_next_lat", lat, 2);

        // Arbitration: both ports requesting continuously from reset.
        @(negedge clk);
        rst_n = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 12'h004;
        i_req = 1'b1; i_addr = 12'h000;
        @(negedge clk);
        rst_n = 1'b1;
        exp_g[0] = 1'b1; exp_g[1] = 1'b0; exp_g[2] = 1'b1; exp_g[3] = 1'b0;
        g = 0;
        #1;
        for (int c = 0; c < 40 && g < 4; c++) begin
            if (d_ready && i_ready) check("arb_both_ready", 32'd1, 32'd0);
            if (d_ready) begin rec[g] = 1'b1; g++; end
            else if (i_ready) begin rec[g] = 1'b0; g++; end
            @(negedge clk);
            #1;
        end
        i_req = 1'b0; d_req = 1'b0;
        check("arb_grants", g, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < g) check($sformatf("arb_grant%0d_is_d", k), {31'd0, rec[k]}, {31'd0, exp_g[k]});
        end
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
